// File: rtl/rt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rt_pkg: shared constants and types for the ray-tracing frame pipeline.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package rt_pkg;

  localparam int MAX_CORES = 4;
  localparam int X_W       = 11;
  localparam int Y_W       = 11;
  localparam int CORE_W    = (MAX_CORES > 1) ? $clog2(MAX_CORES) : 1;
  localparam int CNT_W     = X_W + Y_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } dispatch_state_t;

  // Highest usable core index for a requested extra-core count.
  function automatic logic [CORE_W-1:0] clamp_core_max(input logic [2:0] extra);
    if (int'(extra) > MAX_CORES - 1) begin
      return CORE_W'(MAX_CORES - 1);
    end
    return extra[CORE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_coord_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_coord_counter: raster-order x/y counter with load, advance, last.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_coord_counter
  import rt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [X_W-1:0]   width_in,
  input  logic [Y_W-1:0]   height_in,
  input  logic             advance,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             last,
  output logic [CNT_W-1:0] total
);

  logic [X_W-1:0] r_width;
  logic [Y_W-1:0] r_height;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_line_end;

  assign w_line_end = (r_x == r_width - X_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_width  <= '0;
      r_height <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (load) begin
      r_width  <= width_in;
      r_height <= height_in;
      r_x      <= '0;
      r_y      <= '0;
    end else if (advance) begin
      if (w_line_end) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign x     = r_x;
  assign y     = r_y;
  assign last  = w_line_end && (r_y == r_height - Y_W'(1));
  assign total = CNT_W'(r_width) * CNT_W'(r_height);

endmodule
`default_nettype wire

// File: rtl/pixel_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_dispatcher: raster-order round-robin pixel job scheduler.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_dispatcher
  import rt_pkg::*;
(
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [X_W-1:0]       frame_width,
  input  logic [Y_W-1:0]       frame_height,
  input  logic [2:0]           no_of_extra_cores,
  input  logic [MAX_CORES-1:0] core_ready,
  output logic [MAX_CORES-1:0] core_valid,
  output logic [X_W-1:0]       core_x,
  output logic [Y_W-1:0]       core_y,
  output logic                 core_last,
  input  logic                 pixel_retired,
  output logic                 busy,
  output logic                 frame_done
);

  dispatch_state_t  r_state;
  dispatch_state_t  w_next_state;
  logic [CORE_W-1:0] r_core_idx;
  logic [CORE_W-1:0] r_core_max;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [CNT_W-1:0]  w_retire_next;
  logic [CNT_W-1:0]  w_total;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic              w_last;
  logic              w_fire;
  logic              w_load;
  logic              w_retire_inc;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_fire = (r_state == ST_DISPATCH) && core_ready[r_core_idx];

  pixel_coord_counter u_coord (
    .clk       (aclk),
    .rst       (areset),
    .load      (w_load),
    .width_in  (frame_width),
    .height_in (frame_height),
    .advance   (w_fire),
    .x         (w_x),
    .y         (w_y),
    .last      (w_last),
    .total     (w_total)
  );

  // Retire counting is independent of dispatch and saturates at the frame total.
  assign w_retire_inc  = pixel_retired
                       && ((r_state == ST_DISPATCH) || (r_state == ST_DRAIN))
                       && (r_retire_cnt != w_total);
  assign w_retire_next = r_retire_cnt + CNT_W'(w_retire_inc);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((frame_width == '0) || (frame_height == '0)) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_DISPATCH;
          end
        end
      end
      ST_DISPATCH: begin
        if (w_fire && w_last) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_retire_next == w_total) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_core_idx   <= '0;
      r_core_max   <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_core_idx   <= '0;
        r_core_max   <= clamp_core_max(no_of_extra_cores);
        r_retire_cnt <= '0;
      end else begin
        if (w_fire) begin
          r_core_idx <= (r_core_idx == r_core_max) ? '0 : r_core_idx + CORE_W'(1);
        end
        r_retire_cnt <= w_retire_next;
      end
    end
  end

  // Outputs decode registered state only; job fields are zeroed outside DISPATCH.
  always_comb begin
    core_valid = '0;
    core_x     = '0;
    core_y     = '0;
    core_last  = 1'b0;
    if (r_state == ST_DISPATCH) begin
      core_valid[r_core_idx] = 1'b1;
      core_x                 = w_x;
      core_y                 = w_y;
      core_last              = w_last;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_dispatcher: frame vectors plus scoreboard of expected jobs.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pixel_dispatcher;
  import rt_pkg::*;

  logic                 clk;
  logic                 areset;
  logic                 start;
  logic [X_W-1:0]       frame_width;
  logic [Y_W-1:0]       frame_height;
  logic [2:0]           no_of_extra_cores;
  logic [MAX_CORES-1:0] core_ready;
  logic [MAX_CORES-1:0] core_valid;
  logic [X_W-1:0]       core_x;
  logic [Y_W-1:0]       core_y;
  logic                 core_last;
  logic                 pixel_retired;
  logic                 busy;
  logic                 frame_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0]  valid;
    logic [10:0] x;
    logic [10:0] y;
    logic        last;
  } job_t;

  typedef struct {
    int         w;
    int         h;
    logic [2:0] extra;
    int         n_cores;
  } frame_vec_t;

  job_t sb_q[$];

  pixel_dispatcher dut (
    .aclk              (clk),
    .areset            (areset),
    .start             (start),
    .frame_width       (frame_width),
    .frame_height      (frame_height),
    .no_of_extra_cores (no_of_extra_cores),
    .core_ready        (core_ready),
    .core_valid        (core_valid),
    .core_x            (core_x),
    .core_y            (core_y),
    .core_last         (core_last),
    .pixel_retired     (pixel_retired),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected jobs of a frame in raster order, cores in strict rotation.
  task automatic push_jobs(input int w, input int h, input int n_cores);
    int   idx = 0;
    job_t j;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        j.valid = 4'(1 << idx);
        j.x     = 11'(xx);
        j.y     = 11'(yy);
        j.last  = (xx == w - 1) && (yy == h - 1);
        sb_q.push_back(j);
        idx = (idx + 1) % n_cores;
      end
    end
  endtask

  // Monitor: compares the offered job against the scoreboard head, pops on a fire.
  always @(negedge clk) begin
    if (!areset) begin
      check("onehot", 32'($countones(core_valid) <= 1), 32'd1);
      if (core_valid != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_job", {28'd0, core_valid}, 32'd0);
        end else begin
          check("job", 32'({core_valid, core_x, core_y, core_last}), 32'(sb_q[0]));
          if ((core_valid & core_ready) != '0) begin
            void'(sb_q.pop_front());
          end
        end
      end else begin
        check("last_idle", 32'(core_last), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h, input logic [2:0] extra);
    frame_width       = X_W'(w);
    frame_height      = Y_W'(h);
    no_of_extra_cores = extra;
    start             = 1'b1;
    step();
    start             = 1'b0;
  endtask

  task automatic wait_queue_empty(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check({tag, "_queue_drained"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic retire_all(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      pixel_retired = 1'b1;
      step();
      pixel_retired = 1'b0;
    end
    check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
    step();
    check({tag, "_done_one_cycle"}, 32'(frame_done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input string tag, input frame_vec_t v);
    push_jobs(v.w, v.h, v.n_cores);
    do_start(v.w, v.h, v.extra);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_queue_empty(tag);
    check({tag, "_drain_no_valid"}, 32'(core_valid), 32'd0);
    check({tag, "_drain_busy"}, 32'(busy), 32'd1);
    check({tag, "_drain_no_done"}, 32'(frame_done), 32'd0);
    retire_all(tag, v.w * v.h);
  endtask

  frame_vec_t vecs[5];

  initial begin
    vecs[0] = '{w: 4, h: 2, extra: 3'd3, n_cores: 4};
    vecs[1] = '{w: 3, h: 1, extra: 3'd1, n_cores: 2};
    vecs[2] = '{w: 5, h: 3, extra: 3'd6, n_cores: 4};
    vecs[3] = '{w: 2, h: 2, extra: 3'd0, n_cores: 1};
    vecs[4] = '{w: 7, h: 1, extra: 3'd2, n_cores: 3};

    areset            = 1'b1;
    start             = 1'b0;
    frame_width       = '0;
    frame_height      = '0;
    no_of_extra_cores = '0;
    core_ready        = '1;
    pixel_retired     = 1'b0;
    repeat (3) step();
    areset = 1'b0;
    check("rst_valid", 32'(core_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_xy", 32'({core_x, core_y, core_last}), 32'd0);
    step();

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i]);
      step();
    end

    // Stall core 1 for five cycles on job 1.
    core_ready = 4'b1101;
    push_jobs(4, 1, 4);
    do_start(4, 1, 3'd3);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(core_valid), 32'h2);
      check("stall_xy", 32'({core_x, core_y}), 32'({11'd1, 11'd0}));
      if (i == 4) core_ready = 4'hF;
      step();
    end
    check("after_stall_valid", 32'(core_valid), 32'h4);
    check("after_stall_x", 32'(core_x), 32'd2);
    wait_queue_empty("stall");
    retire_all("stall", 4);
    step();

    // Zero-width frame goes straight to DONE.
    do_start(0, 5, 3'd3);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_done", 32'(frame_done), 32'd1);
    check("zero_valid", 32'(core_valid), 32'd0);
    step();
    check("zero_idle", 32'({busy, frame_done}), 32'd0);
    step();

    // Reset mid-frame, with an ignored second start.
    push_jobs(4, 2, 4);
    do_start(4, 2, 3'd3);
    frame_width  = 11'd2;
    frame_height = 11'd1;
    start        = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_job3", 32'({core_valid, core_x}), 32'({4'h8, 11'd3}));
    areset = 1'b1;
    step();
    areset = 1'b0;
    sb_q.delete();
    check("midrst_valid", 32'(core_valid), 32'd0);
    check("midrst_xy", 32'({core_x, core_y, core_last}), 32'd0);
    check("midrst_flags", 32'({busy, frame_done}), 32'd0);
    step();
    run_frame("restart", '{w: 2, h: 1, extra: 3'd3, n_cores: 4});
    step();

    // Clamped core count, retires overlapping fires, plus a stray retire in IDLE.
    pixel_retired = 1'b1;
    step();
    pixel_retired = 1'b0;
    check("idle_retire_ignored", 32'({busy, frame_done}), 32'd0);
    push_jobs(3, 2, 4);
    do_start(3, 2, 3'd6);
    for (int k = 0; k < 6; k++) begin
      pixel_retired = (k < 5);
      step();
    end
    pixel_retired = 1'b0;
    check("ovl_drain_no_done", 32'({busy, frame_done}), 32'({1'b1, 1'b0}));
    check("ovl_queue", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    pixel_retired = 1'b1;
    step();
    pixel_retired = 1'b0;
    check("ovl_frame_done", 32'(frame_done), 32'd1);
    step();
    check("ovl_idle", 32'({busy, frame_done}), 32'd0);
    step();

    // Excess retires during a stall saturate the count.
    core_ready = 4'h0;
    push_jobs(2, 1, 2);
    do_start(2, 1, 3'd1);
    pixel_retired = 1'b1;
    repeat (3) step();
    pixel_retired = 1'b0;
    core_ready    = 4'hF;
    step();
    step();
    check("sat_drain", 32'({busy, frame_done, core_valid}), 32'({1'b1, 1'b0, 4'h0}));
    step();
    check("sat_frame_done", 32'(frame_done), 32'd1);
    step();
    check("sat_idle", 32'(busy), 32'd0);
    check("sat_queue", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
